// File: rtl/chan_pkg.sv
// chan_pkg: state encodings, per-channel word indices and w1 field positions shared by chan_seq.
package chan_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_BEGIN, S_GETOFFS, S_GETADDVOL, S_GETSIZE, S_GETLOOP, S_EMIT, S_SAVE, S_NEXT
  } state_t;
  localparam logic [1:0] W_OFFS   = 2'd0;
  localparam logic [1:0] W_ADDVOL = 2'd1;
  localparam logic [1:0] W_SIZE   = 2'd2;
  localparam logic [1:0] W_LOOP   = 2'd3;
  localparam int ADD_MSB     = 31;
  localparam int ADD_LSB     = 14;
  localparam int LOOPENA_BIT = 13;
  localparam int SURR_BIT    = 12;
  localparam int VOLL_MSB    = 11;
  localparam int VOLL_LSB    = 6;
  localparam int VOLR_MSB    = 5;
  localparam int VOLR_LSB    = 0;
endpackage

// File: rtl/chan_addr_calc.sv
// chan_addr_calc: offset advance, end-of-sample test, loop wrap and sample address sum.
module chan_addr_calc #(
  parameter int ABITS = 22
) (
  input  logic [31:0]      i_w0,
  input  logic [17:0]      i_add,
  input  logic [19:0]      i_size,
  input  logic [19:0]      i_loop,
  input  logic             i_loopena,
  input  logic [23:0]      i_base,
  output logic [31:0]      o_off,
  output logic             o_oversize,
  output logic [ABITS-1:0] o_addr
);
  logic [32:0] w_sum;
  logic [19:0] w_int;
  always_comb begin
    w_sum      = {1'b0, i_w0} + {15'b0, i_add};
    o_oversize = w_sum[32:12] >= {1'b0, i_size};
    w_int      = (o_oversize && i_loopena) ? w_sum[31:12] + i_loop : w_sum[31:12];
    o_off      = {w_int, w_sum[11:0]};
    // base bits above ABITS-1 fall away with the modulo, so the full 24-bit field is fed in
    o_addr     = ABITS'({i_base, 8'h00}) + ABITS'(w_int);
  end
endmodule

// File: rtl/chan_seq.sv
// chan_seq: per-frame channel walker that fetches channel state, emits 6 mixer bytes and saves the offset.
module chan_seq
  import chan_pkg::*;
#(
  parameter int NCH   = 32,
  parameter int ABITS = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [$clog2(NCH)+1:0]   rd_addr,
  input  logic [31:0]              rd_data,
  output logic [$clog2(NCH)+1:0]   wr_addr,
  output logic [31:0]              wr_data,
  output logic                     wr_stb,
  input  logic                     sync_stb,
  input  logic [NCH-1:0]           ch_enas,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_mix,
  output logic                     done_stb,
  output logic [$clog2(NCH)-1:0]   done_ch,
  output logic                     overrun_stb
);
  localparam int CW = $clog2(NCH);
  state_t           r_state;
  logic [CW:0]      r_ch;
  logic             r_pend;
  logic [31:0]      r_w0, r_w1;
  logic [27:0]      r_w2, r_w3;
  logic [2:0]       r_idx;
  logic [CW:0]      w_nch;
  logic [CW-1:0]    w_ch;
  logic [2:0]       w_nk;
  logic [31:0]      w_off;
  logic             w_over;
  logic [ABITS-1:0] w_addr;
  logic [23:0]      w_a24;
  logic [7:0]       w_byte;

  chan_addr_calc #(.ABITS(ABITS)) u_calc (
    .i_w0      (r_w0),
    .i_add     (r_w1[ADD_MSB:ADD_LSB]),
    .i_size    (r_w2[27:8]),
    .i_loop    (r_w3[27:8]),
    .i_loopena (r_w1[LOOPENA_BIT]),
    .i_base    ({r_w3[15:0], r_w2[7:0]}),
    .o_off     (w_off),
    .o_oversize(w_over),
    .o_addr    (w_addr)
  );

  // w_byte is the byte to present next: index 0 when leaving GETLOOP, else the one after r_idx
  always_comb begin
    w_ch   = r_ch[CW-1:0];
    w_nch  = r_ch + (CW+1)'(1);
    w_nk   = (r_state == S_EMIT) ? r_idx + 3'd1 : 3'd0;
    w_a24  = 24'(w_addr);
    w_byte = (w_nk == 3'd0) ? w_off[11:4] :
             (w_nk == 3'd1) ? {2'b00, r_w1[VOLL_MSB:VOLL_LSB]} :
             (w_nk == 3'd2) ? {2'b00, r_w1[VOLR_MSB:VOLR_LSB] ^ {6{r_w1[SURR_BIT]}}} :
             (w_nk == 3'd3) ? w_a24[23:16] :
             (w_nk == 3'd4) ? w_a24[15:8] : w_a24[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ch        <= '0;
      r_pend      <= 1'b0;
      r_w0        <= '0;
      r_w1        <= '0;
      r_w2        <= '0;
      r_w3        <= '0;
      r_idx       <= '0;
      rd_addr     <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_stb      <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_mix     <= 1'b0;
      done_stb    <= 1'b0;
      done_ch     <= '0;
      overrun_stb <= 1'b0;
    end else begin
      wr_stb      <= 1'b0;
      done_stb    <= 1'b0;
      overrun_stb <= 1'b0;
      if (sync_stb && r_state != S_IDLE) begin
        overrun_stb <= 1'b1;
        r_pend      <= 1'b1;
      end
      case (r_state)
        S_IDLE: if (sync_stb || r_pend) begin
          r_state <= S_BEGIN;
          r_ch    <= '0;
          rd_addr <= '0;
          r_pend  <= 1'b0;
        end
        S_BEGIN: begin
          if (r_ch[CW]) r_state <= S_IDLE;
          else if (!ch_enas[w_ch]) r_state <= S_NEXT;
          else begin
            r_state <= S_GETOFFS;
            rd_addr <= {w_ch, W_ADDVOL};
          end
        end
        S_GETOFFS: begin
          r_w0    <= rd_data;
          rd_addr <= {w_ch, W_SIZE};
          r_state <= S_GETADDVOL;
        end
        S_GETADDVOL: begin
          r_w1    <= rd_data;
          rd_addr <= {w_ch, W_LOOP};
          r_state <= S_GETSIZE;
        end
        S_GETSIZE: begin
          r_w2    <= rd_data[27:0];
          r_state <= S_GETLOOP;
        end
        S_GETLOOP: begin
          r_w3 <= rd_data[27:0];
          if (w_over && !r_w1[LOOPENA_BIT]) begin
            done_stb <= 1'b1;
            done_ch  <= w_ch;
            r_state  <= S_NEXT;
          end else begin
            out_valid <= 1'b1;
            out_data  <= w_byte;
            out_mix   <= w_nk < 3'd3;
            r_idx     <= '0;
            r_state   <= S_EMIT;
          end
        end
        S_EMIT: if (out_ready) begin
          if (r_idx == 3'd5) begin
            out_valid <= 1'b0;
            wr_stb    <= 1'b1;
            wr_data   <= w_off;
            wr_addr   <= {w_ch, W_OFFS};
            r_state   <= S_SAVE;
          end else begin
            r_idx    <= w_nk;
            out_data <= w_byte;
            out_mix  <= w_nk < 3'd3;
          end
        end
        S_SAVE: r_state <= S_NEXT;
        S_NEXT: begin
          r_ch    <= w_nch;
          rd_addr <= {w_nch[CW-1:0], W_OFFS};
          r_state <= S_BEGIN;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chan_seq.sv
// tb_chan_seq: directed scenario bench for chan_seq with a behavioural state RAM.
module tb_chan_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd_addr, wr_addr;
  logic [31:0] rd_data, wr_data;
  logic        wr_stb, sync_stb, out_valid, out_ready, out_mix, done_stb, overrun_stb;
  logic [3:0]  ch_enas;
  logic [7:0]  out_data;
  logic [1:0]  done_ch;

  logic [31:0] ram [16];
  logic        cfg_we;
  logic [3:0]  cfg_a;
  logic [31:0] cfg_d;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] bq [256];
  logic       mq [256];
  int nb = 0, nwr = 0, ndone = 0, novr = 0, nstall = 0, stall_err = 0, wr_at = 0;
  logic [3:0]  last_wa;
  logic [31:0] last_wd;
  logic [1:0]  last_dch;
  logic        p_stall = 1'b0;
  logic [7:0]  p_data;

  chan_seq #(.NCH(4), .ABITS(22)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_stb(wr_stb),
    .sync_stb(sync_stb), .ch_enas(ch_enas),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_mix(out_mix),
    .done_stb(done_stb), .done_ch(done_ch), .overrun_stb(overrun_stb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cfg_we) ram[cfg_a] <= cfg_d;
    else if (wr_stb) ram[wr_addr] <= wr_data;
    rd_data <= ram[rd_addr];
  end

  always @(negedge clk) begin
    if (out_valid && out_ready && nb < 256) begin
      bq[nb] = out_data;
      mq[nb] = out_mix;
      nb++;
    end
    if (wr_stb) begin
      nwr++;
      last_wa = wr_addr;
      last_wd = wr_data;
      wr_at = nb;
    end
    if (done_stb) begin
      ndone++;
      last_dch = done_ch;
    end
    if (overrun_stb) novr++;
    if (p_stall && (!out_valid || out_data !== p_data)) stall_err++;
    p_stall = out_valid && !out_ready;
    p_data = out_data;
    if (p_stall) nstall++;
  end

  function automatic logic [31:0] mk_w1(input logic [17:0] add, input logic le, input logic su,
                                        input logic [5:0] vl, input logic [5:0] vr);
    return {add, le, su, vl, vr};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] a, input logic [31:0] d);
    cfg_we = 1'b1;
    cfg_a = a;
    cfg_d = d;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic set_ch(input logic [1:0] ch, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3);
    cfg({ch, 2'd0}, w0);
    cfg({ch, 2'd1}, w1);
    cfg({ch, 2'd2}, w2);
    cfg({ch, 2'd3}, w3);
  endtask

  task automatic pulse_sync;
    sync_stb = 1'b1;
    tick(1);
    sync_stb = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if ({wr_stb, out_valid, done_stb, overrun_stb, out_mix} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 00000", {wr_stb, out_valid, done_stb, overrun_stb, out_mix});
    end
    n_checks++;
    if (out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_out_data got %h exp 00", out_data);
    end
    n_checks++;
    if ({rd_addr, wr_addr, done_ch} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_addrs got %h/%h/%h exp 0/0/0", rd_addr, wr_addr, done_ch);
    end
  endtask

  task automatic check_bytes(input string nm, input int b0, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4, input logic [7:0] e5);
    logic [7:0] ex [6];
    logic [5:0] mix;
    ex = '{e0, e1, e2, e3, e4, e5};
    n_checks++;
    if (nb - b0 != 6) begin
      n_fail++;
      $display("FAIL %s_count got %0d exp 6", nm, nb - b0);
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (bq[b0 + k] !== ex[k]) begin
        n_fail++;
        $display("FAIL %s_byte%0d got %h exp %h", nm, k, bq[b0 + k], ex[k]);
      end
      mix[k] = mq[b0 + k];
    end
    n_checks++;
    if (mix !== 6'b000111) begin
      n_fail++;
      $display("FAIL %s_mix got %b exp 000111", nm, mix);
    end
  endtask

  task automatic test_basic;
    int b0, w0c, t;
    ch_enas = 4'b0010;
    set_ch(2'd1, 32'h0000_1000, mk_w1(18'h1000, 1'b0, 1'b0, 6'h2A, 6'h15), 32'h0001_005C, 32'h0000_002A);
    b0 = nb;
    w0c = nwr;
    t = -1;
    pulse_sync;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (wr_stb) begin
        t = i;
        break;
      end
    end
    n_checks++;
    if (t != 14) begin
      n_fail++;
      $display("FAIL basic_latency got %0d exp 14", t);
    end
    tick(40);
    check_bytes("basic", b0, 8'h00, 8'h2A, 8'h15, 8'h2A, 8'h5C, 8'h02);
    n_checks++;
    if (nwr - w0c != 1 || last_wa !== 4'd4 || last_wd !== 32'h0000_2000) begin
      n_fail++;
      $display("FAIL basic_write got n=%0d a=%h d=%h exp n=1 a=4 d=00002000", nwr - w0c, last_wa, last_wd);
    end
    n_checks++;
    if (wr_at - b0 != 6) begin
      n_fail++;
      $display("FAIL basic_wr_order got %0d exp 6", wr_at - b0);
    end
  endtask

  task automatic test_loop;
    int b0, w0c;
    set_ch(2'd1, 32'h000F_F0A5, mk_w1(18'h1000, 1'b1, 1'b1, 6'h2A, 6'h05), 32'h0001_005C, 32'h0FFF_802A);
    b0 = nb;
    w0c = nwr;
    pulse_sync;
    tick(60);
    check_bytes("loop", b0, 8'h0A, 8'h2A, 8'h3A, 8'h2A, 8'h5C, 8'h80);
    n_checks++;
    if (nwr - w0c != 1 || ram[4] !== 32'h0008_00A5) begin
      n_fail++;
      $display("FAIL loop_write got n=%0d ram=%h exp n=1 ram=000800a5", nwr - w0c, ram[4]);
    end
  endtask

  task automatic test_noloop;
    int b0, w0c, d0;
    set_ch(2'd1, 32'h000F_F0A5, mk_w1(18'h1000, 1'b0, 1'b1, 6'h2A, 6'h05), 32'h0001_005C, 32'h0FFF_802A);
    b0 = nb;
    w0c = nwr;
    d0 = ndone;
    pulse_sync;
    tick(60);
    n_checks++;
    if (nb - b0 != 0 || nwr - w0c != 0) begin
      n_fail++;
      $display("FAIL noloop_quiet got bytes=%0d writes=%0d exp 0/0", nb - b0, nwr - w0c);
    end
    n_checks++;
    if (ndone - d0 != 1 || last_dch !== 2'd1) begin
      n_fail++;
      $display("FAIL noloop_done got n=%0d ch=%0d exp n=1 ch=1", ndone - d0, last_dch);
    end
    n_checks++;
    if (ram[4] !== 32'h000F_F0A5) begin
      n_fail++;
      $display("FAIL noloop_w0 got %h exp 000ff0a5", ram[4]);
    end
  endtask

  task automatic test_stall;
    int b0, w0c, s0, e0;
    bit did;
    set_ch(2'd1, 32'h0000_1000, mk_w1(18'h1000, 1'b0, 1'b0, 6'h2A, 6'h15), 32'h0001_005C, 32'h0000_002A);
    b0 = nb;
    w0c = nwr;
    s0 = nstall;
    e0 = stall_err;
    did = 1'b0;
    pulse_sync;
    for (int i = 0; i < 80; i++) begin
      if (!did && nb - b0 == 2) begin
        out_ready = 1'b0;
        tick(5);
        out_ready = 1'b1;
        did = 1'b1;
      end else tick(1);
    end
    check_bytes("stall", b0, 8'h00, 8'h2A, 8'h15, 8'h2A, 8'h5C, 8'h02);
    n_checks++;
    if (nstall - s0 != 5 || stall_err != e0) begin
      n_fail++;
      $display("FAIL stall_hold got stall=%0d err=%0d exp 5/0", nstall - s0, stall_err - e0);
    end
    n_checks++;
    if (nwr - w0c != 1 || wr_at - b0 != 6 || ram[4] !== 32'h0000_2000) begin
      n_fail++;
      $display("FAIL stall_write got n=%0d at=%0d ram=%h exp 1/6/00002000", nwr - w0c, wr_at - b0, ram[4]);
    end
  endtask

  task automatic test_overrun;
    int w0c, o0;
    set_ch(2'd1, 32'h0000_1000, mk_w1(18'h1000, 1'b0, 1'b0, 6'h2A, 6'h15), 32'h0001_005C, 32'h0000_002A);
    w0c = nwr;
    o0 = novr;
    pulse_sync;
    tick(4);
    pulse_sync;
    tick(4);
    pulse_sync;
    tick(90);
    n_checks++;
    if (novr - o0 != 2) begin
      n_fail++;
      $display("FAIL overrun_pulses got %0d exp 2", novr - o0);
    end
    n_checks++;
    if (nwr - w0c != 2 || ram[4] !== 32'h0000_3000) begin
      n_fail++;
      $display("FAIL overrun_frames got n=%0d ram=%h exp 2/00003000", nwr - w0c, ram[4]);
    end
  endtask

  task automatic test_reset_mid;
    int w0c;
    ch_enas = 4'b0001;
    set_ch(2'd0, 32'h0000_1000, mk_w1(18'h1000, 1'b0, 1'b0, 6'h2A, 6'h15), 32'h0001_005C, 32'h0000_002A);
    w0c = nwr;
    pulse_sync;
    tick(3);
    rst = 1'b1;
    test_reset;
    tick(1);
    rst = 1'b0;
    tick(30);
    n_checks++;
    if (nwr - w0c != 0 || ram[0] !== 32'h0000_1000) begin
      n_fail++;
      $display("FAIL rstmid_nowrite got n=%0d ram=%h exp 0/00001000", nwr - w0c, ram[0]);
    end
    pulse_sync;
    tick(40);
    n_checks++;
    if (nwr - w0c != 1 || last_wa !== 4'd0 || ram[0] !== 32'h0000_2000) begin
      n_fail++;
      $display("FAIL rstmid_restart got n=%0d a=%h ram=%h exp 1/0/00002000", nwr - w0c, last_wa, ram[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    sync_stb = 1'b0;
    ch_enas = 4'b0;
    out_ready = 1'b1;
    cfg_we = 1'b0;
    cfg_a = '0;
    cfg_d = '0;
    for (int i = 0; i < 16; i++) ram[i] = '0;
    tick(2);
    test_reset;
    tick(1);
    rst = 1'b0;
    tick(2);
    test_basic;
    test_loop;
    test_noloop;
    test_stall;
    test_overrun;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
